wb_sram_slave: RTL and testbench

//  Wishbone B4 classic/registered-feedback SRAM target on one slave port of
//  the NxN interconnect; consumes SADR/SCTI/SBTE/SDAT_W/SCYC/SSEL/SSTB/SWE.

---
 rtl/wb_types_pkg.sv | 26 ++
 rtl/wb_burst_addr_gen.sv | 37 +++
 rtl/wb_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_wb_sram_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_types_pkg.sv
// Shared Wishbone B4 encodings for the SRAM target.
//   cti_e        : cycle type identifier (classic, incrementing burst, end-of-burst)
//   bte_e        : burst type extension (linear, wrap4, wrap8, wrap16)
//   sram_state_e : target FSM states
package wb_types_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } sram_state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-word-index generator for Wishbone incrementing bursts.
// Ports:
//   idx     in  IDX_W  current word index
//   bte     in  bte_e  burst type extension
//   nxt_idx out IDX_W  index of the following beat
//   carry   out 1      linear increment rolled over the top of the memory
module wb_burst_addr_gen
  import wb_types_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] idx,
  input  bte_e             bte,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             carry
);

  logic [IDX_W:0]   inc;
  logic [IDX_W-1:0] mask;

  assign inc = {1'b0, idx} + (IDX_W+1)'(1);

  // Mask selects the bits that are allowed to count; the rest are held.
  // Linear counts across the whole index (wraps modulo DEPTH).
  always_comb begin
    case (bte)
      WRAP4:   mask = IDX_W'(3);
      WRAP8:   mask = IDX_W'(7);
      WRAP16:  mask = IDX_W'(15);
      default: mask = '1;
    endcase
  end

  assign nxt_idx = (idx & ~mask) | (inc[IDX_W-1:0] & mask);
  assign carry   = (bte == LINEAR) & inc[IDX_W];

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic / registered-feedback SRAM target.
// One-cycle access latency; incrementing bursts (linear, wrap4/8/16) at one
// beat per clock. Memory is DEPTH words of WB_DATA_WIDTH bits, not cleared
// by reset.
// Ports:
//   clk, rstn (synchronous, active-low)
//   ADR   byte address        CTI  cycle type         BTE  burst type
//   DAT_W write data          DAT_R read data (valid with ACK)
//   CYC, STB, WE, SEL         Wishbone request signals
//   ACK   transfer acknowledge
//   ERR   error acknowledge (only when WB_SRAM_ERR_EN is defined, else 0)
// Build option:
//   WB_SRAM_ERR_EN : out-of-range accesses (below BASE_ADDR or at/after word
//                    DEPTH) answer ERR instead of ACK; a linear burst crossing
//                    the top errs on that beat and ends. When undefined,
//                    addresses alias modulo DEPTH.
module wb_sram_slave
  import wb_types_pkg::*;
#(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       DEPTH         = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SEL_W  = WB_DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(SEL_W);

`ifdef WB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_e state, state_d;

  logic [IDX_W-1:0]         idx_p0, idx_d, rd_idx;
  logic                     ack_p0, ack_d;
  logic                     err_p0, err_d;
  logic [WB_DATA_WIDTH-1:0] dat_r_p0;

  logic                     wr_en;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     nxt_carry;

  // Address decode: signed offset from BASE_ADDR, then byte -> word.
  logic signed [WB_ADDR_WIDTH:0] adr_off;
  logic [WB_ADDR_WIDTH-1:0]      adr_word;
  logic [IDX_W-1:0]              adr_idx;
  logic                          adr_oor;

  assign adr_off  = $signed({1'b0, ADR}) - $signed({1'b0, BASE_ADDR});
  assign adr_word = adr_off[WB_ADDR_WIDTH-1:0] >> BSHIFT;
  assign adr_idx  = adr_word[IDX_W-1:0];
  // Negative offset, or any word bit above the index range.
  assign adr_oor  = adr_off[WB_ADDR_WIDTH] | (|(adr_word >> IDX_W));

  wb_burst_addr_gen #(.IDX_W(IDX_W)) u_addr_gen (
    .idx     (idx_p0),
    .bte     (bte_e'(BTE)),
    .nxt_idx (nxt_idx),
    .carry   (nxt_carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic. SINGLE also carries the one-cycle ERR response.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (CYC && STB) begin
          if (CTI == INCR && !(ERR_EN && adr_oor)) state_d = BURST;
          else                                     state_d = SINGLE;
        end
      end
      SINGLE: state_d = IDLE;
      BURST: begin
        if (!CYC || !STB || CTI == EOB) state_d = IDLE;
        else if (ERR_EN && nxt_carry)   state_d = SINGLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next response and the word it reads. In a burst the
  // following beat is prefetched from the counter while the current beat
  // is being accepted, so ACK can stay high back-to-back.
  always_comb begin
    ack_d  = 1'b0;
    err_d  = 1'b0;
    idx_d  = idx_p0;
    rd_idx = idx_p0;
    case (state)
      IDLE: begin
        if (CYC && STB) begin
          idx_d  = adr_idx;
          rd_idx = adr_idx;
          if (ERR_EN && adr_oor) err_d = 1'b1;
          else                   ack_d = 1'b1;
        end
      end
      BURST: begin
        if (CYC && STB && CTI != EOB) begin
          if (ERR_EN && nxt_carry) begin
            err_d = 1'b1;
          end else begin
            ack_d  = 1'b1;
            idx_d  = nxt_idx;
            rd_idx = nxt_idx;
          end
        end
      end
      default: ;
    endcase
  end

  // Stage p0: registered response and beat counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_p0   <= '0;
      ack_p0   <= 1'b0;
      err_p0   <= 1'b0;
      dat_r_p0 <= '0;
    end else begin
      idx_p0   <= idx_d;
      ack_p0   <= ack_d;
      err_p0   <= err_d;
      dat_r_p0 <= ack_d ? mem[rd_idx] : '0;
    end
  end

  // A beat commits on the edge where it is acknowledged and still strobed.
  // The read above sees the pre-write contents, which is fine because the
  // prefetched word always differs from the word being written.
  assign wr_en = rstn & CYC & STB & ack_p0 & WE;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (SEL[b]) mem[idx_p0][8*b +: 8] <= DAT_W[8*b +: 8];
      end
    end
  end

  assign ACK   = ack_p0;
  assign ERR   = err_p0;
  assign DAT_R = dat_r_p0;

endmodule

// File: tb/tb_wb_sram_slave.sv
module tb_wb_sram_slave;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] ADR = '0;
  logic [2:0]    CTI = '0;
  logic [1:0]    BTE = '0;
  logic [DW-1:0] DAT_W = '0;
  logic [DW-1:0] DAT_R;
  logic          CYC = 1'b0;
  logic          STB = 1'b0;
  logic          WE = 1'b0;
  logic [3:0]    SEL = '0;
  logic          ACK;
  logic          ERR;

  always #5 clk = ~clk;

  wb_sram_slave #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .DEPTH         (DEPTH),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .ADR   (ADR),
    .CTI   (CTI),
    .BTE   (BTE),
    .DAT_W (DAT_W),
    .DAT_R (DAT_R),
    .CYC   (CYC),
    .STB   (STB),
    .WE    (WE),
    .SEL   (SEL),
    .ACK   (ACK),
    .ERR   (ERR)
  );

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Word visited on beat k of a burst starting at word 'start'.
  function automatic int exp_word(input int start, input int k, input logic [1:0] bte);
    int n, base;
    if (bte == 2'd0) return (((start + k) % DEPTH) + DEPTH) % DEPTH;
    n    = 1 << (int'(bte) + 1);
    base = start - (start % n);
    return base + ((start % n) + k) % n;
  endfunction

  // tail: 0 = end with EOB/classic and release the bus,
  //       1 = drop STB after the last beat (CYC held),
  //       2 = keep requesting another beat (CTI=010, SEL=0) and return.
  task automatic run_beats(input string tag, input int start, input int n,
                           input logic [1:0] bte, input bit we, input bit classic,
                           input int tail, input logic [3:0] sel,
                           input bit rnd, input logic [31:0] wfix);
    for (int k = 0; k < n; k++) begin
      int w, waited;
      logic [31:0] wd;
      w   = exp_word(start, k, bte);
      wd  = rnd ? $urandom : wfix;
      ADR = (k == 0) ? BASE + 32'(start) * 32'd4 : 32'hFFFF_FFFC;
      CTI = classic ? 3'b000 : ((k == n - 1 && tail == 0) ? 3'b111 : 3'b010);
      BTE = bte;
      WE  = we;
      DAT_W = wd;
      SEL = sel;
      CYC = 1'b1;
      STB = 1'b1;
      if (!we) exp_q.push_back(model[w]);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!ACK && waited < 8);
      chk({tag, " latency"}, 32'(waited), (k == 0) ? 32'd2 : 32'd1);
      chk({tag, " err"}, {31'b0, ERR}, 32'd0);
      if (!we) chk({tag, " data"}, DAT_R, exp_q.pop_front());
      @(posedge clk);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model[w][8*b +: 8] = wd[8*b +: 8];
      end
      #1;
    end
    if (tail == 0) begin
      CYC = 1'b0;
      STB = 1'b0;
      @(negedge clk);
      chk({tag, " ack after"}, {31'b0, ACK}, 32'd0);
      @(posedge clk);
      #1;
    end else if (tail == 1) begin
      STB = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " ack after drop"}, {31'b0, ACK}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
    end else begin
      ADR = 32'hFFFF_FFFC;
      CTI = 3'b010;
      SEL = 4'h0;
      STB = 1'b1;
    end
  endtask

`ifdef WB_SRAM_ERR_EN
  task automatic err_single(input string tag, input logic [31:0] addr);
    ADR = addr;
    CTI = 3'b000;
    WE  = 1'b0;
    CYC = 1'b1;
    STB = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " err"}, {31'b0, ERR}, 32'd1);
    chk({tag, " ack"}, {31'b0, ACK}, 32'd0);
    chk({tag, " dat"}, DAT_R, 32'd0);
    @(posedge clk);
    #1;
    CYC = 1'b0;
    STB = 1'b0;
    @(negedge clk);
    chk({tag, " err one cycle"}, {31'b0, ERR}, 32'd0);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack", {31'b0, ACK}, 32'd0);
    chk("reset err", {31'b0, ERR}, 32'd0);
    chk("reset dat", DAT_R, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Fill the whole memory with one linear write burst so the model is known.
    run_beats("preload", 0, DEPTH, 2'd0, 1'b1, 1'b0, 0, 4'hF, 1'b1, 32'h0);

    // Classic write then read at byte offset 0x10
    run_beats("classic wr", 4, 1, 2'd0, 1'b1, 1'b1, 0, 4'hF, 1'b0, 32'hDEAD_BEEF);
    run_beats("classic rd", 4, 1, 2'd0, 1'b0, 1'b1, 0, 4'hF, 1'b0, 32'h0);

    // Byte-lane write at byte offset 0x20
    run_beats("lane fill", 8, 1, 2'd0, 1'b1, 1'b1, 0, 4'hF, 1'b0, 32'hFFFF_FFFF);
    run_beats("lane wr", 8, 1, 2'd0, 1'b1, 1'b1, 0, 4'h3, 1'b0, 32'h1234_5678);
    run_beats("lane rd", 8, 1, 2'd0, 1'b0, 1'b1, 0, 4'hF, 1'b0, 32'h0);

    // Bursts: linear, wrap4, wrap8, wrap16 write + linear readback
    run_beats("linear4", 0, 4, 2'd0, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);
    run_beats("wrap4", 6, 4, 2'd1, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);
    run_beats("wrap8", 13, 8, 2'd2, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);
    run_beats("wrap16 wr", 21, 16, 2'd3, 1'b1, 1'b0, 0, 4'hF, 1'b1, 32'h0);
    run_beats("wrap16 rd", 16, 16, 2'd0, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);

    // Wait state mid-burst, then restart from ADR
    run_beats("stb drop", 0, 2, 2'd0, 1'b0, 1'b0, 1, 4'hF, 1'b0, 32'h0);
    run_beats("stb resume", 2, 6, 2'd0, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);

`ifdef WB_SRAM_ERR_EN
    // Linear burst running off the top of memory
    run_beats("cross", DEPTH - 2, 2, 2'd0, 1'b0, 1'b0, 2, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    chk("cross err", {31'b0, ERR}, 32'd1);
    chk("cross ack", {31'b0, ACK}, 32'd0);
    chk("cross dat", DAT_R, 32'd0);
    @(posedge clk);
    #1;
    CYC = 1'b0;
    STB = 1'b0;
    @(negedge clk);
    chk("cross end err", {31'b0, ERR}, 32'd0);
    chk("cross end ack", {31'b0, ACK}, 32'd0);
    @(posedge clk);
    #1;
    // Out-of-range singles
    err_single("oor top", BASE + 32'(DEPTH) * 32'd4);
    err_single("oor below", BASE - 32'd4);
`else
    // Without error reporting, addresses alias modulo DEPTH
    run_beats("cross", DEPTH - 2, 3, 2'd0, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);
    run_beats("alias top", DEPTH, 1, 2'd0, 1'b0, 1'b1, 0, 4'hF, 1'b0, 32'h0);
    run_beats("alias below", -1, 1, 2'd0, 1'b0, 1'b1, 0, 4'hF, 1'b0, 32'h0);
`endif

    // Reset in the middle of a write burst; committed beats must survive
    run_beats("rst burst", 40, 3, 2'd0, 1'b1, 1'b0, 2, 4'hF, 1'b1, 32'h0);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst mid ack", {31'b0, ACK}, 32'd0);
    chk("rst mid err", {31'b0, ERR}, 32'd0);
    chk("rst mid dat", DAT_R, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    CYC  = 1'b0;
    STB  = 1'b0;
    @(posedge clk);
    #1;
    run_beats("rst readback", 40, 4, 2'd0, 1'b0, 1'b0, 0, 4'hF, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
